// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// master: the requester (drives start/A/B); slave: the adder itself.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Sum;
   logic             Cout;

   modport master (
      output start, A, B,
      input  busy, done, Sum, Cout
   );

   modport slave (
      input  start, A, B,
      output busy, done, Sum, Cout
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half adders plus an
// OR on their carries) is reused over WIDTH clocks, LSB first, with a carry
// flop linking successive bits. start/done handshake, registered result.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_add_ctrl_if.slave    bus
);

   // One extra counter bit so the count never wraps inside an operation.
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_out;
   logic             cout_out;
   logic             carry;
   logic [CW-1:0]    count;

   logic             ha0_s;
   logic             ha0_c;
   logic             ha1_s;
   logic             ha1_c;
   logic             bit_sum;
   logic             bit_carry;
   logic             last_bit;

   // First half adder: the two operand bits.
   assign ha0_s = a_sr[0] ^ b_sr[0];
   assign ha0_c = a_sr[0] & b_sr[0];

   // Second half adder: partial sum plus the carry flop.
   assign ha1_s = ha0_s ^ carry;
   assign ha1_c = ha0_s & carry;

   // Full-adder outputs for the current bit.
   assign bit_sum   = ha1_s;
   assign bit_carry = ha0_c | ha1_c;

   assign last_bit  = (count == LAST_BIT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start only matters in IDLE; DONE always lasts one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (last_bit)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         RUN:     bus.busy = 1'b1;
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: capture on accepted start, shift one bit per RUN edge, and
   // publish the result only on the edge that finishes the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         sum_sr   <= '0;
         carry    <= 1'b0;
         count    <= '0;
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sr  <= bus.A;
                  b_sr  <= bus.B;
                  carry <= 1'b0;
                  count <= '0;
               end
            end
            RUN: begin
               sum_sr <= {bit_sum, sum_sr[WIDTH-1:1]};
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               carry  <= bit_carry;
               count  <= count + CW'(1);
               if (last_bit) begin
                  sum_out  <= {bit_sum, sum_sr[WIDTH-1:1]};
                  cout_out <= bit_carry;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.Sum  = sum_out;
   assign bus.Cout = cout_out;

endmodule
